// File: rtl/sensor_emulator_if.sv
// sensor_emulator_if: AHB-Lite slave bus bundle (select/ready/transfer/address/data in, read data and ready out)
interface sensor_emulator_if;
  logic        HSEL;
  logic        HREADY;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  modport master(output HSEL, HREADY, HWRITE, HADDR, HWDATA, HSIZE, HTRANS, input HRDATA, HREADYOUT);
  modport slave(input HSEL, HREADY, HWRITE, HADDR, HWDATA, HSIZE, HTRANS, output HRDATA, HREADYOUT);
endinterface

// File: rtl/sensor_emulator.sv
// sensor_emulator: AHB-Lite programmable fork/crank pulse emulator
// Ports: HCLK clock, HRESETn async active-low reset, bus AHB-Lite slave
// (CTRL, FORK_PERIOD, CRANK_PERIOD, COUNT at HADDR[3:2]), nFork/nCrank
// registered active-low sensor pulses.
module sensor_channel #(
  parameter int LOW_TICKS = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        en,
  input  logic        tick,
  input  logic        clr,
  input  logic [15:0] period,
  output logic        n_out,
  output logic [15:0] cnt
);
  localparam logic [1:0] OFF = 2'd0, LOW = 2'd1, HIGH = 2'd2;
  localparam logic [15:0] LT = 16'(LOW_TICKS);
  localparam logic [15:0] MINP = 16'(LOW_TICKS + 1);
  logic [1:0] state;
  logic [15:0] phase, shadow, eff, ph1, cnt_d;
  logic stop, start, to_high;
  assign ph1 = phase + 16'd1;
  assign eff = shadow > LT ? shadow : MINP;
  assign stop = !en || period == 16'd0;
  assign start = !stop && tick && (state == OFF || (state == HIGH && ph1 == eff));
  assign to_high = !stop && tick && state == LOW && ph1 == LT;
  // a COUNT clear wins over a simultaneous pulse start
  assign cnt_d = clr ? 16'd0 : start ? cnt + 16'd1 : cnt;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state  <= OFF;
      phase  <= 16'd0;
      shadow <= 16'd0;
      cnt    <= 16'd0;
      n_out  <= 1'b1;
    end else begin
      cnt <= cnt_d;
      if (stop) begin
        state <= OFF;
        phase <= 16'd0;
        n_out <= 1'b1;
      end else if (start) begin
        state  <= LOW;
        phase  <= 16'd0;
        shadow <= period;
        n_out  <= 1'b0;
      end else if (to_high) begin
        state <= HIGH;
        phase <= ph1;
        n_out <= 1'b1;
      end else if (tick && state != OFF) phase <= ph1;
    end
endmodule

module sensor_emulator #(
  parameter int TICK_DIV  = 1000,
  parameter int LOW_TICKS = 2
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  sensor_emulator_if.slave   bus,
  output logic               nFork,
  output logic               nCrank
);
  localparam logic [15:0] DIV1 = 16'(TICK_DIV - 1);
  logic [1:0] ctrl, idx_q;
  logic [15:0] fork_per, crank_per, pre, fork_cnt, crank_cnt;
  logic wr_q, rd_q, sel, active, tick, clr;
  logic unused_bits;
  assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA[31:16]};
  assign sel = bus.HREADY && bus.HSEL && bus.HTRANS != 2'b00;
  assign active = |ctrl;
  assign tick = active && pre == DIV1;
  assign clr = wr_q && idx_q == 2'd3;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRDATA = !rd_q ? 32'd0 :
                      idx_q == 2'd0 ? {30'd0, ctrl} :
                      idx_q == 2'd1 ? {16'd0, fork_per} :
                      idx_q == 2'd2 ? {16'd0, crank_per} : {crank_cnt, fork_cnt};
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      idx_q     <= 2'd0;
      ctrl      <= 2'd0;
      fork_per  <= 16'd0;
      crank_per <= 16'd0;
      pre       <= 16'd0;
    end else begin
      wr_q  <= sel && bus.HWRITE;
      rd_q  <= sel && !bus.HWRITE;
      idx_q <= bus.HADDR[3:2];
      if (wr_q && idx_q == 2'd0) ctrl <= bus.HWDATA[1:0];
      if (wr_q && idx_q == 2'd1) fork_per <= bus.HWDATA[15:0];
      if (wr_q && idx_q == 2'd2) crank_per <= bus.HWDATA[15:0];
      pre <= (!active || tick) ? 16'd0 : pre + 16'd1;
    end
  sensor_channel #(.LOW_TICKS(LOW_TICKS)) u_fork (
    .HCLK(HCLK), .HRESETn(HRESETn), .en(ctrl[0]), .tick(tick), .clr(clr),
    .period(fork_per), .n_out(nFork), .cnt(fork_cnt)
  );
  sensor_channel #(.LOW_TICKS(LOW_TICKS)) u_crank (
    .HCLK(HCLK), .HRESETn(HRESETn), .en(ctrl[1]), .tick(tick), .clr(clr),
    .period(crank_per), .n_out(nCrank), .cnt(crank_cnt)
  );
endmodule

// File: tb/tb_sensor_emulator.sv
// tb_sensor_emulator: directed self-checking bench for sensor_emulator (TICK_DIV=4, LOW_TICKS=2)
module tb_sensor_emulator;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic nFork, nCrank;
  int checks = 0;
  int failures = 0;
  sensor_emulator_if bus();
  sensor_emulator #(.TICK_DIV(4), .LOW_TICKS(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus), .nFork(nFork), .nCrank(nCrank)
  );
  always #5 HCLK = ~HCLK;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.HSEL = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask
  task automatic ahb_write(input logic [1:0] r, input logic [31:0] d);
    @(negedge HCLK);
    bus.HSEL = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b1;
    bus.HADDR = {28'd0, r, 2'b00};
    @(negedge HCLK);
    idle();
    bus.HWDATA = d;
    @(negedge HCLK);
  endtask
  task automatic ahb_read(input logic [1:0] r, output logic [31:0] d);
    @(negedge HCLK);
    bus.HSEL = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b0;
    bus.HADDR = {28'd0, r, 2'b00};
    @(negedge HCLK);
    idle();
    #1 d = bus.HRDATA;
  endtask
  task automatic wait_lvl(input bit crank, input logic v, output int n);
    n = 0;
    while (((crank ? nCrank : nFork) !== v) && n < 400) begin
      @(negedge HCLK);
      n++;
    end
  endtask
  logic [31:0] rd;
  int n0, n1, n2, lows;
  initial begin
    bus.HREADY = 1'b1;
    bus.HSIZE = 3'b010;
    bus.HADDR = 32'd0;
    bus.HWDATA = 32'd0;
    idle();
    repeat (3) @(negedge HCLK);
    check("rst_nFork", {31'd0, nFork}, 32'd1);
    check("rst_nCrank", {31'd0, nCrank}, 32'd1);
    check("rst_hrdata", bus.HRDATA, 32'd0);
    HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ahb_read(2'(i), rd);
      check($sformatf("rst_reg%0d", i), rd, 32'd0);
    end
    // fork period 5: 8 low / 12 high
    ahb_write(2'd1, 32'hABCD_0005);
    ahb_write(2'd0, 32'hFFFF_FFFD);
    ahb_read(2'd0, rd);
    check("ctrl_rd", rd, 32'd1);
    ahb_read(2'd1, rd);
    check("fper_rd", rd, 32'd5);
    wait_lvl(0, 0, n0);
    wait_lvl(0, 1, n1);
    check("a_low1", n1, 8);
    wait_lvl(0, 0, n1);
    check("a_high1", n1, 12);
    wait_lvl(0, 1, n1);
    check("a_low2", n1, 8);
    wait_lvl(0, 0, n1);
    check("a_high2", n1, 12);
    check("a_nCrank", {31'd0, nCrank}, 32'd1);
    ahb_read(2'd3, rd);
    check("a_count", rd, 32'h0000_0003);
    // fork period 1 -> effective 3
    ahb_write(2'd0, 32'd0);
    ahb_write(2'd1, 32'd1);
    ahb_write(2'd0, 32'd1);
    wait_lvl(0, 0, n0);
    wait_lvl(0, 1, n1);
    check("b_low", n1, 8);
    wait_lvl(0, 0, n1);
    check("b_high", n1, 4);
    ahb_write(2'd0, 32'd0);
    @(negedge HCLK);
    check("b_off", {31'd0, nFork}, 32'd1);
    lows = 0;
    repeat (30) begin
      @(negedge HCLK);
      if (nFork === 1'b0) lows++;
    end
    check("b_stays_off", lows, 0);
    // crank period change mid-LOW
    ahb_write(2'd2, 32'd6);
    ahb_write(2'd0, 32'd2);
    wait_lvl(1, 0, n0);
    ahb_write(2'd2, 32'd10);
    wait_lvl(1, 1, n1);
    wait_lvl(1, 0, n2);
    check("c_period1", 3 + n1 + n2, 24);
    wait_lvl(1, 1, n1);
    wait_lvl(1, 0, n2);
    check("c_low2", n1, 8);
    check("c_period2", n1 + n2, 40);
    // both channels, simultaneous starts, clear vs start
    ahb_write(2'd0, 32'd0);
    ahb_write(2'd3, 32'd0);
    ahb_write(2'd1, 32'd5);
    ahb_write(2'd2, 32'd5);
    ahb_write(2'd0, 32'd3);
    wait_lvl(0, 0, n0);
    check("d_sync", {31'd0, nCrank}, 32'd0);
    ahb_read(2'd3, rd);
    check("d_count1", rd, 32'h0001_0001);
    repeat (15) @(negedge HCLK);
    ahb_write(2'd3, 32'd0);
    check("d_start2_fork", {31'd0, nFork}, 32'd0);
    check("d_start2_crank", {31'd0, nCrank}, 32'd0);
    ahb_read(2'd3, rd);
    check("d_clr_prio", rd, 32'd0);
    // fork count wrap with crank count parked at 1
    wait_lvl(0, 1, n0);
    wait_lvl(0, 0, n0);
    ahb_write(2'd0, 32'd1);
    @(negedge HCLK);
    force dut.u_fork.cnt_d = 16'hFFFF;
    @(negedge HCLK);
    release dut.u_fork.cnt_d;
    ahb_read(2'd3, rd);
    check("e_forced", rd, 32'h0001_FFFF);
    wait_lvl(0, 1, n0);
    wait_lvl(0, 0, n0);
    ahb_read(2'd3, rd);
    check("e_wrap", rd, 32'h0001_0000);
    // asynchronous reset mid-LOW
    wait_lvl(0, 1, n0);
    wait_lvl(0, 0, n0);
    #3 HRESETn = 1'b0;
    #1;
    check("f_async_nFork", {31'd0, nFork}, 32'd1);
    check("f_rst_hrdata", bus.HRDATA, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ahb_read(2'(i), rd);
      check($sformatf("f_reg%0d", i), rd, 32'd0);
    end
    lows = 0;
    repeat (60) begin
      @(negedge HCLK);
      if (nFork === 1'b0 || nCrank === 1'b0) lows++;
    end
    check("f_no_pulse", lows, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sensor_emulator.md
SENSOR_EMULATOR -- requirements
Module: sensor_emulator

Interface
REQ-001 Parameter TICK_DIV, default 1000: HCLK cycles per emulator tick; legal range 2..65535.
REQ-002 Parameter LOW_TICKS, default 2: active-low pulse width in ticks; legal range 1..255.
REQ-003 HCLK  input  1  clock; all state updates on the rising edge.
REQ-004 HRESETn  input  1  asynchronous, active-low reset.
REQ-005 HSEL  input  1  AHB-Lite slave select.
REQ-006 HREADY  input  1  bus ready; an address phase is valid only when HREADY=1.
REQ-007 HWRITE  input  1  1 = write, 0 = read.
REQ-008 HADDR  input  32  address; only HADDR[3:2] is decoded.
REQ-009 HWDATA  input  32  write data, sampled in the data phase.
REQ-010 HSIZE  input  3  ignored; word access only.
REQ-011 HTRANS  input  2  transfer type; 2'b00 = no transfer.
REQ-012 HRDATA  output  32  read data, valid in the data phase.
REQ-013 HREADYOUT  output  1  tied to 1; zero wait states.
REQ-014 nFork  output  1  emulated fork sensor, active-low, registered.
REQ-015 nCrank  output  1  emulated crank sensor, active-low, registered.

Function
REQ-016 Register map, selected by HADDR[3:2]:
- 0 CTRL: bit0 = fork_en, bit1 = crank_en; all other bits read 0.
- 1 FORK_PERIOD: [15:0], in ticks.
- 2 CRANK_PERIOD: [15:0], in ticks.
- 3 COUNT: read returns {crank_cnt[15:0], fork_cnt[15:0]}; any write clears both counts.
REQ-017 Address phase: HREADY && HSEL && HTRANS!=00 registers the access type (read/write) and the register index; any other address phase registers idle.
REQ-018 A write updates the selected register in the cycle after its address phase, using HWDATA from that data phase.
REQ-019 HRDATA is driven combinationally from the registered index during a read data phase; otherwise HRDATA = 0.
REQ-020 Unused register bits are written as don't-care and read as 0.
REQ-021 Prescaler:
- counts 0..TICK_DIV-1 while fork_en or crank_en is set;
- asserts a one-cycle tick when the count equals TICK_DIV-1, then wraps to 0;
- is held at 0 while both enables are clear.
REQ-022 Each channel has an independent FSM with states OFF, LOW and HIGH; a 16-bit phase counter counts ticks.
REQ-023 OFF: output is 1. On a tick with en=1 and period!=0, the channel latches the period into a shadow register, clears the phase counter, moves to LOW and increments its count.
REQ-024 LOW: output is 0. The phase counter increments on each tick; at phase = LOW_TICKS the channel moves to HIGH.
REQ-025 HIGH: output is 1. The phase counter increments on each tick; at phase = effective period the channel re-latches the period, clears the phase counter, moves to LOW and increments its count.
REQ-026 Effective period = max(shadow, LOW_TICKS+1).
REQ-027 Transitions into LOW from OFF happen only on a tick, so the first falling edge is aligned to the prescaler.
REQ-028 Clearing en, or a register period of 0, forces the channel to OFF on the next clock regardless of state; the output returns to 1 and the phase counter is cleared.
REQ-029 A period written mid-pulse takes effect only at the next transition into LOW.
REQ-030 Output timing: each pulse is LOW_TICKS*TICK_DIV HCLK cycles low; the pulse period is effective_period*TICK_DIV HCLK cycles.
REQ-031 Counts are 16-bit and wrap from 0xFFFF to 0x0000.
REQ-032 If a COUNT clear write and a pulse start occur in the same cycle, the clear has priority and the affected count becomes 0.
REQ-033 Fork and crank pulses may start in the same cycle; each channel updates independently.
REQ-034 nFork and nCrank are flop outputs with no combinational path from any input.

Reset
REQ-035 While HRESETn=0:
- CTRL, both periods, both shadows, both counts, the prescaler and the phase counters are 0;
- both FSMs are OFF and the registered AHB access is idle;
- nFork = nCrank = 1 and HRDATA = 0.
REQ-036 Reset asserted mid-pulse drives the output to 1 immediately (asynchronously); operation after deassertion starts from the REQ-035 state.

Verification (TICK_DIV=4, LOW_TICKS=2)
REQ-037 Write FORK_PERIOD=5, then CTRL=1 -> nFork repeats 8 HCLK low / 12 HCLK high (20-cycle period); nCrank stays 1; after 3 falling edges COUNT reads 0x0000_0003.
REQ-038 FORK_PERIOD=1, CTRL=1 -> effective period is 3: 8 cycles low / 4 cycles high; then write CTRL=0 while nFork=0 -> nFork=1 on the next clock and the FSM returns to OFF.
REQ-039 CRANK_PERIOD=6, CTRL=2; write CRANK_PERIOD=10 during a LOW phase -> the current period stays 24 cycles; the following period is 40 cycles.
REQ-040 Both channels with period 5, CTRL=3 -> simultaneous falling edges; COUNT reads 0x0001_0001 after the first pulse; a write to COUNT in the same cycle as the 2nd pulse start -> COUNT reads 0x0000_0000.
REQ-041 Force fork_cnt to 0xFFFF, then one pulse -> fork_cnt = 0x0000 and crank_cnt is unchanged.
REQ-042 Assert HRESETn=0 mid-LOW -> nFork=1 asynchronously; all registers read 0 after deassertion; no pulse occurs until CTRL is rewritten.
